gin_id_loader: RTL

GIN_ID_LOADER -- requirements
Module: gin_id_loader

---
 rtl/gin_id_loader_if.sv | 32 +++
 rtl/gin_id_loader.sv | 115 +++++++++++
 2 files changed

// File: rtl/gin_id_loader_if.sv
`default_nettype none
// ------------------------------------------------------------------
// gin_id_loader_if: session control, ID stream and strobe bus
// Rev 1.0
// ------------------------------------------------------------------
interface gin_id_loader_if #(
  parameter int ID_SIZE  = 5,
  parameter int NUM_DEST = 12,
  parameter int CNT_W    = $clog2(NUM_DEST + 1)
);
  logic                start;
  logic [CNT_W-1:0]    num_ids;
  logic                cfg_valid;
  logic [ID_SIZE-1:0]  cfg_id;
  logic                cfg_ready;
  logic [NUM_DEST-1:0] set_id;
  logic [ID_SIZE-1:0]  id_out;
  logic                busy;
  logic                done;
  logic                err;

  modport master (
    output start, num_ids, cfg_valid, cfg_id,
    input  cfg_ready, set_id, id_out, busy, done, err
  );

  modport slave (
    input  start, num_ids, cfg_valid, cfg_id,
    output cfg_ready, set_id, id_out, busy, done, err
  );
endinterface
`default_nettype wire

// File: rtl/gin_id_loader.sv
`default_nettype none
// ------------------------------------------------------------------
// gin_id_loader: loads a stream of IDs into controllers 0..n-1 in order
// Rev 1.0
// ------------------------------------------------------------------
module gin_id_loader #(
  parameter int ID_SIZE  = 5,
  parameter int NUM_DEST = 12,
  parameter int CNT_W    = $clog2(NUM_DEST + 1)
) (
  input  logic             clk,
  input  logic             rst,
  gin_id_loader_if.slave   bus
);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_load = 2'd1;
  localparam logic [1:0] c_done = 2'd2;

  localparam logic [CNT_W-1:0] c_max_ids = CNT_W'(NUM_DEST);

  logic [1:0]          r_state;
  logic [1:0]          w_next_state;
  logic [CNT_W-1:0]    r_idx;
  logic [CNT_W-1:0]    r_target;
  logic                r_err;
  logic [NUM_DEST-1:0] r_set_id;
  logic [ID_SIZE-1:0]  r_id_out;

  logic                w_start_ok;
  logic                w_hs;
  logic                w_last;
  logic [NUM_DEST-1:0] w_onehot;
  logic                w_cfg_ready;
  logic                w_busy;
  logic                w_done;

  assign w_start_ok = bus.start && (bus.num_ids != '0) && (bus.num_ids <= c_max_ids);
  assign w_hs       = bus.cfg_valid && (r_state == c_load);
  assign w_last     = w_hs && (r_idx == (r_target - CNT_W'(1)));

  always_comb begin
    w_onehot = '0;
    for (int k = 0; k < NUM_DEST; k++) begin
      w_onehot[k] = (r_idx == CNT_W'(k));
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_idle:  if (w_start_ok) w_next_state = c_load;
      c_load:  if (w_last)     w_next_state = c_done;
      c_done:                  w_next_state = c_idle;
      default:                 w_next_state = c_idle;
    endcase
  end

  // Moore outputs; done coincides with the final strobe because both follow the last handshake
  always_comb begin
    w_cfg_ready = 1'b0;
    w_done      = 1'b0;
    w_busy      = (r_state != c_idle);
    case (r_state)
      c_load:  w_cfg_ready = 1'b1;
      c_done:  w_done      = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx    <= '0;
      r_target <= '0;
      r_err    <= 1'b0;
      r_set_id <= '0;
      r_id_out <= '0;
    end else begin
      r_set_id <= w_hs ? w_onehot : '0;
      if (w_hs) begin
        r_id_out <= bus.cfg_id;
        r_idx    <= r_idx + CNT_W'(1);
      end
      // start only matters while idle; an illegal count leaves target/idx alone
      if ((r_state == c_idle) && bus.start) begin
        if (w_start_ok) begin
          r_target <= bus.num_ids;
          r_idx    <= '0;
          r_err    <= 1'b0;
        end else begin
          r_err    <= 1'b1;
        end
      end
    end
  end

  assign bus.cfg_ready = w_cfg_ready;
  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
  assign bus.err       = r_err;
  assign bus.set_id    = r_set_id;
  assign bus.id_out    = r_id_out;

endmodule
`default_nettype wire
